// File: rtl/memory_bank_pkg.sv
// memory_bank_pkg: shared types and helpers for the memory_bank slice.
// Holds the controller state encoding and the even-parity helper used when
// the bank is built with MEMORY_BANK_PARITY_EN.

package memory_bank_pkg;

   // Sweep controller states.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   // Widest data word the parity helper accepts. Callers zero-extend their
   // data to this width. Zero-extension does not change an XOR reduction.
   localparam int PAR_MAX_W = 256;

   // Even parity: the XOR of all data bits. Storing this bit makes the XOR of
   // the data and the parity bit together come out as zero.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/mem_parity.sv
// mem_parity: parity generate/check for memory_bank words.
// This module is used only when the bank is built with MEMORY_BANK_PARITY_EN.
// Write side: produces the stored parity bit. The bit is inverted when
// par_inj is set, so a test can plant a corrupted word on purpose.
// Check side: flags a word whose stored parity disagrees with its data.

module mem_parity
   import memory_bank_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] wr_data,
   input  logic             par_inj,
   output logic             wr_par,
   input  logic [WIDTH-1:0] chk_data,
   input  logic             chk_par,
   output logic             chk_err
);

   assign wr_par  = even_parity(PAR_MAX_W'(wr_data)) ^ par_inj;
   assign chk_err = even_parity(PAR_MAX_W'(chk_data)) ^ chk_par;

endmodule

// File: rtl/memory_bank.sv
// memory_bank: a WIDTH x DEPTH memory with one write port and one read port.
// Reads are registered, with write-first forwarding when the read and write
// addresses match. A hardware sweep zeroes the whole array after reset and on
// each clr request.
// Optional feature: define MEMORY_BANK_PARITY_EN to store an even-parity bit
// per word. That build adds the par_inj and parity_err ports.
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | sweep writes zero to mem[cnt] once per cycle; requests are ignored
// READY | normal operation: writes, reads with forwarding, clr accepted

module memory_bank
   import memory_bank_pkg::*;
#(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
`ifdef MEMORY_BANK_PARITY_EN
   input  logic              par_inj,
   output logic              parity_err,
`endif
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              busy
);

`ifdef MEMORY_BANK_PARITY_EN
   localparam int WORD_W = WIDTH + 1;
`else
   localparam int WORD_W = WIDTH;
`endif

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;

   logic [WORD_W-1:0]   mem [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_W-1:0]   mem_wdata;
   logic                do_read;

   logic [WORD_W-1:0]   wr_word;
   logic [WORD_W-1:0]   rd_word;
   logic                fwd;

`ifdef MEMORY_BANK_PARITY_EN
   logic                wr_par;
   logic                chk_err;

   // The parity bit sits above the data bits in each stored word.
   mem_parity #(
      .WIDTH (WIDTH)
   ) u_parity (
      .wr_data  (wr_data),
      .par_inj  (par_inj),
      .wr_par   (wr_par),
      .chk_data (rd_word[WIDTH-1:0]),
      .chk_par  (rd_word[WIDTH]),
      .chk_err  (chk_err)
   );

   assign wr_word = {wr_par, wr_data};
`else
   assign wr_word = wr_data;
`endif

   // Write-first: a read at the address being written this cycle returns the
   // new word, including its parity bit, so the check covers it too.
   assign fwd     = wr_en && (wr_addr == rd_addr);
   assign rd_word = fwd ? wr_word : mem[rd_addr];

   assign busy = (state_q == CLEAR);

   // State register and sweep counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, array write port selection and read strobe.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_addr  = wr_addr;
      mem_wdata = wr_word;
      do_read   = 1'b0;
      unique case (state_q)
         CLEAR: begin
            // The all-zero word already carries correct even parity.
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = READY;
            end
         end
         READY: begin
            // clr takes priority: any write or read in the same cycle is dropped.
            if (clr) begin
               state_d = CLEAR;
            end else begin
               mem_we  = wr_en;
               do_read = rd_en;
            end
         end
      endcase
   end

   // Array storage. It has no reset; the sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   // Registered read port. rd_data holds its value when no read is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
`ifdef MEMORY_BANK_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         rd_valid <= do_read;
         if (do_read) begin
            rd_data <= rd_word[WIDTH-1:0];
         end
`ifdef MEMORY_BANK_PARITY_EN
         parity_err <= do_read && chk_err;
`endif
      end
   end

endmodule

// File: tb/tb_memory_bank.sv
// tb_memory_bank: self-checking bench for memory_bank with WIDTH=8 and DEPTH=4.
// A word-level reference model is updated on each rising edge. The compare
// process checks it against the DUT on each falling edge. Directed sequences
// pin literal values; randomized traffic follows them.

module tb_memory_bank;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              clk     = 1'b0;
   logic              reset   = 1'b1;
   logic              clr     = 1'b0;
   logic              wr_en   = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [WIDTH-1:0]  wr_data = '0;
   logic              rd_en   = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              busy;
`ifdef MEMORY_BANK_PARITY_EN
   logic              par_inj = 1'b0;
   logic              parity_err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memory_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
`ifdef MEMORY_BANK_PARITY_EN
      .par_inj    (par_inj),
      .parity_err (parity_err),
`endif
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy)
   );

   // Reference model: array contents, remaining sweep cycles, expected outputs.
   logic [WIDTH-1:0] m_mem [DEPTH];
   bit               m_par [DEPTH];
   int               m_sweep = DEPTH;
   logic [WIDTH-1:0] m_data  = '0;
   bit               m_valid = 1'b0;
   bit               m_perr  = 1'b0;

   task automatic model_zero();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = '0;
         m_par[i] = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_sweep = DEPTH;
         m_valid = 1'b0;
         m_data  = '0;
         m_perr  = 1'b0;
         model_zero();
      end else if (m_sweep > 0) begin
         m_sweep = m_sweep - 1;
         m_valid = 1'b0;
         m_perr  = 1'b0;
      end else if (clr) begin
         m_sweep = DEPTH;
         m_valid = 1'b0;
         m_perr  = 1'b0;
         model_zero();
      end else begin
         if (wr_en) begin
            m_mem[wr_addr] = wr_data;
`ifdef MEMORY_BANK_PARITY_EN
            m_par[wr_addr] = (^wr_data) ^ par_inj;
`else
            m_par[wr_addr] = ^wr_data;
`endif
         end
         m_valid = rd_en;
         m_perr  = 1'b0;
         if (rd_en) begin
            m_data = m_mem[rd_addr];
            m_perr = ((^m_mem[rd_addr]) != m_par[rd_addr]);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_sweep > 0));
      chk("rd_valid", 32'(rd_valid), 32'(m_valid));
      chk("rd_data", 32'(rd_data), 32'(m_data));
`ifdef MEMORY_BANK_PARITY_EN
      chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
   end

   task automatic step(input bit r, input bit c, input bit we, input int wa, input int wd,
                       input bit re, input int ra, input bit inj = 1'b0);
      @(negedge clk);
      #1;
      reset   = r;
      clr     = c;
      wr_en   = we;
      wr_addr = ADDR_W'(wa);
      wr_data = WIDTH'(wd);
      rd_en   = re;
      rd_addr = ADDR_W'(ra);
`ifdef MEMORY_BANK_PARITY_EN
      par_inj = inj;
`else
      if (inj) begin
         checks = checks + 0;
      end
`endif
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic count_busy(input string name);
      int n = 0;
      while (busy && n < 20) begin
         n++;
         idle();
      end
      chk(name, 32'(n), 32'(DEPTH));
   endtask

   task automatic read_all_zero(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 0, 0, 0, 0, 1, i);
         idle();
         chk(name, 32'(rd_data), 32'h00);
         chk({name, "_v"}, 32'(rd_valid), 32'h1);
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog expired at %0t", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("reset_busy", 32'(busy), 32'h1);
      chk("reset_valid", 32'(rd_valid), 32'h0);
      chk("reset_data", 32'(rd_data), 32'h0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle();
      count_busy("busy_after_reset");
      read_all_zero("rd_init");

      step(0, 0, 1, 0, 'hA5, 0, 0);
      step(0, 0, 1, 3, 'h3C, 0, 0);
      step(0, 0, 0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("b2b_first", 32'(rd_data), 32'h3C);
      chk("b2b_first_v", 32'(rd_valid), 32'h1);
      idle();
      chk("b2b_second", 32'(rd_data), 32'hA5);
      chk("b2b_second_v", 32'(rd_valid), 32'h1);
      idle();
      chk("b2b_done_v", 32'(rd_valid), 32'h0);
      chk("b2b_hold", 32'(rd_data), 32'hA5);

      step(0, 0, 1, 2, 'h77, 1, 2);
      idle();
      chk("fwd", 32'(rd_data), 32'h77);

      step(0, 1, 1, 1, 'hFF, 1, 1);
      idle();
      chk("clr_valid", 32'(rd_valid), 32'h0);
      count_busy("busy_after_clr");
      read_all_zero("rd_after_clr");

      step(0, 1, 0, 0, 0, 0, 0);
      idle();
      idle();
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      count_busy("busy_after_sweep_reset");

      step(0, 0, 1, 1, 'h5A, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rdreset_valid", 32'(rd_valid), 32'h0);
      chk("rdreset_data", 32'(rd_data), 32'h0);
      step(0, 0, 0, 0, 0, 0, 0);
      count_busy("busy_after_read_reset");

`ifdef MEMORY_BANK_PARITY_EN
      step(0, 0, 1, 1, 'h0F, 0, 0, 1'b1);
      step(0, 0, 1, 2, 'h0F, 0, 0, 1'b0);
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 2);
      chk("perr_inj", 32'(parity_err), 32'h1);
      idle();
      chk("perr_clean", 32'(parity_err), 32'h0);
`endif

      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 1) == 1),
              int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(0, 255)),
              ($urandom_range(0, 9) < 6),
              int'($urandom_range(0, DEPTH - 1)),
              ($urandom_range(0, 7) == 0));
      end
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_bank.md
# memory_bank

Parametrised, clocked successor to the 4×8-bit store/address memory: a WIDTH×DEPTH single-write, single-read memory with registered read, write-first forwarding and a hardware clear sequencer that zeroes every word after reset or on request. It replaces the demux/byte-cell/mux arrangement wherever the design needs more words, wider words or synchronous read timing.

## Interface
- WIDTH, 8, data bits per word (≥1)
- DEPTH, 4, number of words; power of two, ≥2
- ADDR_W, $clog2(DEPTH), derived localparam, not overridable
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- clr  input  1  synchronous request to re-zero the whole array
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  WIDTH  write data
- rd_en  input  1  read strobe
- rd_addr  input  ADDR_W  read address
- rd_data  output  WIDTH  registered read data
- rd_valid  output  1  rd_data updated this cycle
- busy  output  1  clear sweep in progress; requests ignored
- par_inj  input  1  (MEMORY_BANK_PARITY_EN only) invert stored parity on this write
- parity_err  output  1  (MEMORY_BANK_PARITY_EN only) read word failed parity check

## Operation
- FSM states CLEAR, READY.
- Reset asserted: state=CLEAR, sweep counter=0, busy=1, rd_data=0, rd_valid=0, parity_err=0. Array contents not reset directly; the sweep zeroes them.
- CLEAR: each cycle writes 0 (with correct parity) to mem[cnt], cnt+1. After writing address DEPTH-1 → READY, cnt wraps to 0. wr_en, rd_en, clr ignored; rd_valid=0.
- READY: wr_en=1 → mem[wr_addr]<=wr_data. rd_en=1 → rd_data<=mem[rd_addr], rd_valid<=1; else rd_valid<=0, rd_data holds.
- Simultaneous wr_en and rd_en with rd_addr==wr_addr: rd_data returns wr_data (write-first). Different addresses: independent.
- clr=1 in READY: → CLEAR next cycle; same-cycle wr_en and rd_en are dropped (clr wins), rd_valid<=0.
- reset mid-sweep or mid-read: immediate return to CLEAR, sweep restarts at 0, pending read discarded.
- busy = (state==CLEAR).

## Timing
- Read latency 1: rd_en sampled at edge N, rd_data/rd_valid valid after edge N, for one cycle.
- Write visible to a read issued on the same edge (forwarding) and to all later reads.
- Sweep length exactly DEPTH cycles: busy high for DEPTH edges after reset deassertion, or for DEPTH edges following the edge that samples clr.
- Back-to-back reads every cycle supported; rd_valid stays high throughout.

## Configuration
- MEMORY_BANK_PARITY_EN defined: each word stores WIDTH+1 bits, extra bit = even parity of data (XOR of data bits), inverted when par_inj=1 with wr_en. On read, parity_err<=rd_en & mismatch, aligned with rd_valid; 0 otherwise and on reset. Forwarded reads check the parity being written. Sweep writes correct parity.
- Not defined: no parity bit stored; par_inj and parity_err ports absent.

## Structure
- Package memory_bank_pkg: state typedef (CLEAR, READY), even-parity function.
- Array, sweep counter and FSM inline in memory_bank; one sub-module, mem_parity (parity generate/check), instantiated only under MEMORY_BANK_PARITY_EN.

## Test plan
- Release reset, WIDTH=8, DEPTH=4 → busy high exactly 4 cycles, then 0; read all 4 addresses → 0x00 each, rd_valid one cycle after each rd_en.
- Write 0xA5@0, 0x3C@3; read 3 then 0 back-to-back → 0x3C then 0xA5, rd_valid high both cycles.
- Same-cycle write 0x77@2 and read @2 → rd_data=0x77 next cycle.
- After writes, pulse clr together with wr_en (0xFF@1) and rd_en → no write, rd_valid=0, busy 4 cycles, all words read 0x00.
- Assert reset for one cycle during a sweep and during a read → rd_valid=0, rd_data=0, sweep restarts, busy 4 cycles after release.
- MEMORY_BANK_PARITY_EN: write 0x0F@1 with par_inj=1, 0x0F@2 with par_inj=0; read both → parity_err=1 then 0.
